// File: rtl/fifo_wb_master.sv
// Stream-driven classic Wishbone master: header/address/data words in, read data plus status trailer out.
// Optional per-beat watchdog enabled by defining FIFO_WB_MASTER_TIMEOUT_EN.
module fifo_wb_master #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst_i,
    input  logic [31:0] cmd_dat,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    output logic [31:0] rsp_dat,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] m_adr_o,
    output logic [31:0] m_dat_o,
    input  logic [31:0] m_dat_i,
    output logic        m_cyc_o,
    output logic        m_stb_o,
    output logic        m_we_o,
    output logic [3:0]  m_sel_o,
    input  logic        m_ack_i,
    input  logic        m_err_i
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_WDATA, S_BUS, S_RDOUT, S_DRAIN, S_ZFILL, S_STATUS
    } state_t;

    state_t      state_q, state_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic [31:0] rsp_dat_q, rsp_dat_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic        bus_q, bus_d;
    logic        we_q, we_d;
    logic        rd_q, rd_d;
    logic [8:0]  rem_q, rem_d;     // beats not yet completed; reused as drain/zero-fill count
    logic [8:0]  acked_q, acked_d;
    logic [15:0] tag_q, tag_d;
    logic        err_q, err_d;
    logic        ill_q, ill_d;

    logic        cmd_fire, rsp_fire, tmo_hit, beat_fail;

    assign cmd_fire  = cmd_valid && cmd_ready_q;
    assign rsp_fire  = rsp_valid_q && rsp_ready;
    assign beat_fail = m_err_i || tmo_hit;

`ifdef FIFO_WB_MASTER_TIMEOUT_EN
    logic [15:0] tmo_q;

    assign tmo_hit = (state_q == S_BUS) && (tmo_q == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst_i || state_q != S_BUS || m_ack_i || beat_fail) begin
            tmo_q <= 16'd0;
        end else begin
            tmo_q <= tmo_q + 16'd1;
        end
    end
`else
    logic unused_tmo;
    assign unused_tmo = ^TIMEOUT_CYCLES;
    assign tmo_hit    = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_valid_d = rsp_valid_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        bus_d       = bus_q;
        we_d        = we_q;
        rd_d        = rd_q;
        rem_d       = rem_q;
        acked_d     = acked_q;
        tag_d       = tag_q;
        err_d       = err_q;
        ill_d       = ill_q;
        case (state_q)
            S_IDLE: if (cmd_fire) begin
                tag_d   = cmd_dat[15:0];
                rem_d   = {1'b0, cmd_dat[23:16]} + 9'd1;
                acked_d = 9'd0;
                rd_d    = cmd_dat[30];
                err_d   = cmd_dat[31];
                ill_d   = cmd_dat[31];
                state_d = cmd_dat[31] ? S_STATUS : S_ADDR;
            end
            S_ADDR: if (cmd_fire) begin
                adr_d = {cmd_dat[31:2], 2'b00};
                if (rd_q) begin
                    bus_d   = 1'b1;
                    state_d = S_BUS;
                end else begin
                    state_d = S_WDATA;
                end
            end
            S_WDATA: if (cmd_fire) begin
                dat_d   = cmd_dat;
                bus_d   = 1'b1;
                we_d    = 1'b1;
                state_d = S_BUS;
            end
            S_BUS: if (beat_fail) begin
                bus_d = 1'b0;
                we_d  = 1'b0;
                err_d = 1'b1;
                if (rd_q) begin
                    // The failed beat and every unissued beat come back as zero words.
                    rsp_dat_d   = 32'h0;
                    rsp_valid_d = 1'b1;
                    state_d     = S_ZFILL;
                end else if (rem_q == 9'd1) begin
                    state_d = S_STATUS;
                end else begin
                    rem_d   = rem_q - 9'd1;
                    state_d = S_DRAIN;
                end
            end else if (m_ack_i) begin
                bus_d   = 1'b0;
                we_d    = 1'b0;
                acked_d = acked_q + 9'd1;
                adr_d   = adr_q + 32'd4;
                rem_d   = rem_q - 9'd1;
                if (rd_q) begin
                    rsp_dat_d   = m_dat_i;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RDOUT;
                end else begin
                    state_d = (rem_q == 9'd1) ? S_STATUS : S_WDATA;
                end
            end
            S_RDOUT: if (rsp_fire) begin
                rsp_valid_d = 1'b0;
                if (rem_q == 9'd0) begin
                    state_d = S_STATUS;
                end else begin
                    bus_d   = 1'b1;
                    state_d = S_BUS;
                end
            end
            S_DRAIN: if (cmd_fire) begin
                rem_d = rem_q - 9'd1;
                if (rem_q == 9'd1) state_d = S_STATUS;
            end
            S_ZFILL: if (rsp_fire) begin
                if (rem_q == 9'd1) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_STATUS;
                end else begin
                    rem_d = rem_q - 9'd1;
                end
            end
            S_STATUS: begin
                // Trailer is loaded one cycle after entry, leaving a gap after the last data word.
                if (!rsp_valid_q) begin
                    rsp_dat_d   = {err_q, ill_q, 5'b0, acked_q, tag_q};
                    rsp_valid_d = 1'b1;
                end else if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        cmd_ready_d = (state_d == S_IDLE) || (state_d == S_ADDR) ||
                      (state_d == S_WDATA) || (state_d == S_DRAIN);
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            cmd_ready_q <= 1'b0;
            rsp_dat_q   <= 32'h0;
            rsp_valid_q <= 1'b0;
            adr_q       <= 32'h0;
            dat_q       <= 32'h0;
            bus_q       <= 1'b0;
            we_q        <= 1'b0;
            rd_q        <= 1'b0;
            rem_q       <= 9'd0;
            acked_q     <= 9'd0;
            tag_q       <= 16'h0;
            err_q       <= 1'b0;
            ill_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_valid_q <= rsp_valid_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            bus_q       <= bus_d;
            we_q        <= we_d;
            rd_q        <= rd_d;
            rem_q       <= rem_d;
            acked_q     <= acked_d;
            tag_q       <= tag_d;
            err_q       <= err_d;
            ill_q       <= ill_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_dat   = rsp_dat_q;
    assign rsp_valid = rsp_valid_q;
    assign m_adr_o   = adr_q;
    assign m_dat_o   = dat_q;
    assign m_cyc_o   = bus_q;
    assign m_stb_o   = bus_q;
    assign m_we_o    = we_q;
    assign m_sel_o   = 4'hF;

endmodule

// File: tb/tb_fifo_wb_master.sv
// Directed bench for fifo_wb_master: stream driver, Wishbone responder and per-scenario checks.
module tb_fifo_wb_master;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] cmd_dat = 32'h0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] rsp_dat;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] m_adr_o, m_dat_o;
    logic [31:0] m_dat_i = 32'h0;
    logic        m_cyc_o, m_stb_o, m_we_o;
    logic [3:0]  m_sel_o;
    logic        m_ack_i = 1'b0;
    logic        m_err_i = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fifo_wb_master #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst_i(rst_i),
        .cmd_dat(cmd_dat), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .rsp_dat(rsp_dat), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_dat_i(m_dat_i),
        .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o), .m_sel_o(m_sel_o),
        .m_ack_i(m_ack_i), .m_err_i(m_err_i)
    );

    // Responder configuration (written by tests) and beat log (written by responder).
    int          s_lat = 0;
    int          s_err_beat = 0;
    int          s_start = 0;
    bit          s_never = 1'b0;
    logic [31:0] s_base = 32'h0;
    int          s_beats = 0;
    int          s_cnt = 0;
    logic [31:0] b_adr [0:63];
    logic [31:0] b_dat [0:63];
    logic        b_we  [0:63];
    logic [3:0]  b_sel [0:63];

    always @(posedge clk) begin
        #1;
        if (rst_i) begin
            m_ack_i = 1'b0;
            m_err_i = 1'b0;
            s_cnt   = 0;
        end else if (m_ack_i || m_err_i) begin
            m_ack_i = 1'b0;
            m_err_i = 1'b0;
        end else if (m_stb_o && m_cyc_o && !s_never) begin
            if (s_cnt >= s_lat) begin
                b_adr[s_beats % 64] = m_adr_o;
                b_dat[s_beats % 64] = m_dat_o;
                b_we[s_beats % 64]  = m_we_o;
                b_sel[s_beats % 64] = m_sel_o;
                s_beats = s_beats + 1;
                s_cnt   = 0;
                if (s_beats - s_start == s_err_beat) begin
                    m_err_i = 1'b1;
                end else begin
                    m_ack_i = 1'b1;
                    m_dat_i = s_base + 32'(s_beats - s_start);
                end
            end else begin
                s_cnt = s_cnt + 1;
            end
        end
    end

    task automatic slave_cfg(input int lat, input int err_beat, input logic [31:0] base, input bit never);
        s_lat      = lat;
        s_err_beat = err_beat;
        s_base     = base;
        s_never    = never;
        s_start    = s_beats;
    endtask

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic send_word(input logic [31:0] w);
        int n = 0;
        cmd_dat   = w;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            checks++; errors++;
            $display("FAIL cmd_accept: word %h not accepted, cmd_ready=%b required 1", w, cmd_ready);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic get_rsp(output logic [31:0] w, input bit tog);
        logic [31:0] held = 32'h0;
        bit seen = 1'b0;
        bit done = 1'b0;
        int n = 0;
        w = 32'hxxxx_xxxx;
        while (!done && n < 400) begin
            rsp_ready = tog ? ~rsp_ready : 1'b1;
            if (rsp_valid) begin
                if (seen) begin
                    checks++;
                    if (rsp_dat !== held) begin
                        errors++;
                        $display("FAIL rsp_stable: rsp_dat=%h changed, required %h", rsp_dat, held);
                    end
                end
                held = rsp_dat;
                seen = 1'b1;
                if (rsp_ready) begin
                    w    = rsp_dat;
                    done = 1'b1;
                end
            end
            @(negedge clk);
            n++;
        end
        if (!tog) rsp_ready = 1'b0;
        if (!done) begin
            checks++; errors++;
            $display("FAIL rsp_wait: no response word, rsp_valid=%b required 1", rsp_valid);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({cmd_ready, rsp_valid, m_cyc_o, m_stb_o, m_we_o} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: rdy/vld/cyc/stb/we=%b required 00000",
                     {cmd_ready, rsp_valid, m_cyc_o, m_stb_o, m_we_o});
        end
        checks++;
        if ({rsp_dat, m_adr_o, m_dat_o} !== 96'h0) begin
            errors++;
            $display("FAIL reset_data: rsp=%h adr=%h dat=%h required 0", rsp_dat, m_adr_o, m_dat_o);
        end
        checks++;
        if (m_sel_o !== 4'hF) begin
            errors++;
            $display("FAIL reset_sel: sel=%h required F", m_sel_o);
        end
        rst_i = 1'b0;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: cmd_ready=%b required 1", cmd_ready);
        end
    endtask

    task automatic test_single_write();
        logic [31:0] w;
        slave_cfg(0, 0, 32'h0, 1'b0);
        send_word(32'h0000_00A5);
        send_word(32'h0200_0010);
        send_word(32'hDEAD_BEEF);
        get_rsp(w, 1'b0);
        checks++;
        if (s_beats - s_start !== 1) begin
            errors++;
            $display("FAIL wr_beats: beats=%0d required 1", s_beats - s_start);
        end
        checks++;
        if ({b_adr[s_start % 64], b_dat[s_start % 64], b_we[s_start % 64], b_sel[s_start % 64]}
            !== {32'h0200_0010, 32'hDEAD_BEEF, 1'b1, 4'hF}) begin
            errors++;
            $display("FAIL wr_beat: adr=%h dat=%h we=%b sel=%h required 02000010 deadbeef 1 f",
                     b_adr[s_start % 64], b_dat[s_start % 64], b_we[s_start % 64], b_sel[s_start % 64]);
        end
        checks++;
        if (w !== 32'h0001_00A5) begin
            errors++;
            $display("FAIL wr_trailer: got %h required 000100a5", w);
        end
    endtask

    task automatic test_read_burst();
        logic [31:0] w;
        logic [31:0] exp_adr [0:3] = '{32'h100, 32'h104, 32'h108, 32'h10C};
        slave_cfg(1, 0, 32'h0, 1'b0);
        send_word(32'h4003_0007);
        send_word(32'h0000_0100);
        for (int i = 0; i < 4; i++) begin
            get_rsp(w, 1'b0);
            checks++;
            if (w !== 32'(i + 1)) begin
                errors++;
                $display("FAIL rd_word%0d: got %h required %h", i, w, 32'(i + 1));
            end
        end
        get_rsp(w, 1'b0);
        checks++;
        if (w !== 32'h0004_0007) begin
            errors++;
            $display("FAIL rd_trailer: got %h required 00040007", w);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (b_adr[(s_start + i) % 64] !== exp_adr[i] || b_we[(s_start + i) % 64] !== 1'b0) begin
                errors++;
                $display("FAIL rd_adr%0d: adr=%h we=%b required %h 0", i,
                         b_adr[(s_start + i) % 64], b_we[(s_start + i) % 64], exp_adr[i]);
            end
        end
    endtask

    task automatic test_write_error();
        logic [31:0] w;
        slave_cfg(0, 2, 32'h0, 1'b0);
        send_word(32'h0003_0001);
        send_word(32'h0000_0800);
        send_word(32'h1111_1111);
        send_word(32'h2222_2222);
        send_word(32'h3333_3333);
        send_word(32'h4444_4444);
        get_rsp(w, 1'b0);
        checks++;
        if (s_beats - s_start !== 2) begin
            errors++;
            $display("FAIL werr_beats: beats=%0d required 2", s_beats - s_start);
        end
        checks++;
        if (b_dat[(s_start + 1) % 64] !== 32'h2222_2222 || b_adr[(s_start + 1) % 64] !== 32'h804) begin
            errors++;
            $display("FAIL werr_beat2: adr=%h dat=%h required 00000804 22222222",
                     b_adr[(s_start + 1) % 64], b_dat[(s_start + 1) % 64]);
        end
        checks++;
        if (w !== 32'h8001_0001) begin
            errors++;
            $display("FAIL werr_trailer: got %h required 80010001", w);
        end
    endtask

    task automatic test_read_error_bp();
        logic [31:0] w;
        slave_cfg(0, 1, 32'h0, 1'b0);
        send_word(32'h4002_0002);
        send_word(32'h0000_0200);
        for (int i = 0; i < 3; i++) begin
            get_rsp(w, 1'b1);
            checks++;
            if (w !== 32'h0) begin
                errors++;
                $display("FAIL rerr_word%0d: got %h required 0", i, w);
            end
        end
        get_rsp(w, 1'b1);
        rsp_ready = 1'b0;
        checks++;
        if (w !== 32'h8000_0002) begin
            errors++;
            $display("FAIL rerr_trailer: got %h required 80000002", w);
        end
        checks++;
        if (s_beats - s_start !== 1) begin
            errors++;
            $display("FAIL rerr_beats: beats=%0d required 1", s_beats - s_start);
        end
    endtask

    task automatic test_reserved();
        logic [31:0] w;
        slave_cfg(0, 0, 32'h0, 1'b0);
        send_word(32'hC000_0009);
        get_rsp(w, 1'b0);
        checks++;
        if (w !== 32'hC000_0009) begin
            errors++;
            $display("FAIL resv_trailer: got %h required c0000009", w);
        end
        checks++;
        if (s_beats - s_start !== 0) begin
            errors++;
            $display("FAIL resv_beats: beats=%0d required 0", s_beats - s_start);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] w;
        slave_cfg(0, 0, 32'hA000_0000, 1'b0);
        send_word(32'h0000_0011);
        send_word(32'h0000_0203);
        send_word(32'h1234_5678);
        get_rsp(w, 1'b0);
        checks++;
        if (w !== 32'h0001_0011 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready: trailer=%h cmd_ready=%b required 00010011 1", w, cmd_ready);
        end
        checks++;
        if (b_adr[s_start % 64] !== 32'h0000_0200) begin
            errors++;
            $display("FAIL b2b_align: adr=%h required 00000200", b_adr[s_start % 64]);
        end
        send_word(32'h4001_0022);
        send_word(32'hFFFF_FFFE);
        get_rsp(w, 1'b0);
        checks++;
        if (w !== 32'hA000_0002) begin
            errors++;
            $display("FAIL wrap_word0: got %h required a0000002", w);
        end
        get_rsp(w, 1'b0);
        checks++;
        if (w !== 32'hA000_0003) begin
            errors++;
            $display("FAIL wrap_word1: got %h required a0000003", w);
        end
        get_rsp(w, 1'b0);
        checks++;
        if (w !== 32'h0002_0022) begin
            errors++;
            $display("FAIL wrap_trailer: got %h required 00020022", w);
        end
        checks++;
        if (b_adr[(s_start + 1) % 64] !== 32'hFFFF_FFFC || b_adr[(s_start + 2) % 64] !== 32'h0) begin
            errors++;
            $display("FAIL wrap_adr: adr=%h,%h required fffffffc,00000000",
                     b_adr[(s_start + 1) % 64], b_adr[(s_start + 2) % 64]);
        end
    endtask

    task automatic test_reset_midburst();
        int  n = 0;
        bit  stray = 1'b0;
        slave_cfg(0, 0, 32'h0, 1'b0);
        send_word(32'h4003_0005);
        send_word(32'h0000_0040);
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        rst_i = 1'b1;
        @(negedge clk);
        checks++;
        if ({rsp_valid, m_cyc_o, m_stb_o} !== 3'b0) begin
            errors++;
            $display("FAIL rst_mid: vld/cyc/stb=%b required 000", {rsp_valid, m_cyc_o, m_stb_o});
        end
        rst_i     = 1'b0;
        rsp_ready = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (rsp_valid || m_cyc_o) stray = 1'b1;
        end
        rsp_ready = 1'b0;
        checks++;
        if (stray !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_quiet: stray=%b cmd_ready=%b required 0 1", stray, cmd_ready);
        end
    endtask

`ifdef FIFO_WB_MASTER_TIMEOUT_EN
    task automatic test_timeout();
        logic [31:0] w;
        int hi = 0;
        slave_cfg(0, 0, 32'h0, 1'b1);
        send_word(32'h4000_0003);
        send_word(32'h0000_0300);
        while (m_stb_o && hi < 100) begin
            hi++;
            @(negedge clk);
        end
        checks++;
        if (hi !== 8) begin
            errors++;
            $display("FAIL tmo_len: strobe cycles=%0d required 8", hi);
        end
        get_rsp(w, 1'b0);
        checks++;
        if (w !== 32'h0) begin
            errors++;
            $display("FAIL tmo_word: got %h required 0", w);
        end
        get_rsp(w, 1'b0);
        checks++;
        if (w !== 32'h8000_0003) begin
            errors++;
            $display("FAIL tmo_trailer: got %h required 80000003", w);
        end
        s_never = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_single_write();
        test_read_burst();
        test_write_error();
        test_read_error_bp();
        test_reserved();
        test_back_to_back();
`ifdef FIFO_WB_MASTER_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_midburst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
